// File: rtl/spi_frame_ctrl_pkg.sv
// Shared types and constants for the SPI frame controller.
// Holds the framing/grant enums, default widths and config-bank register map.
package spi_pkg;

   localparam int NUM_REGS_DEF = 5;
   localparam int ADDR_W_DEF   = 7;
   localparam int DATA_W_DEF   = 8;
   localparam int FRAME_BITS   = 1 + ADDR_W_DEF + DATA_W_DEF;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   typedef enum logic {
      SPI = 1'b0,
      LCL = 1'b1
   } grant_t;

   localparam logic [ADDR_W_DEF-1:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W_DEF-1:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W_DEF-1:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W_DEF-1:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W_DEF-1:0] ADDR_PWM_DUTY    = 7'h04;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Local write request/grant and register-bank write port of the SPI frame controller.
// The master modport is the controller side; slave is the requester/register bank side.
interface spi_frame_ctrl_if
   import spi_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              lcl_req;
   logic [ADDR_W-1:0] lcl_addr;
   logic [DATA_W-1:0] lcl_data;
   logic              lcl_gnt;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  lcl_req, lcl_addr, lcl_data,
      output lcl_gnt, wr_en, wr_addr, wr_data
   );

   modport slave (
      output lcl_req, lcl_addr, lcl_data,
      input  lcl_gnt, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/spi_frame_ctrl_wr_arb.sv
// Two-way round-robin write arbiter (SPI pending write vs local requester)
// with a registered write port into the config register bank.
module spi_wr_arb
   import spi_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_req,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_data,
   input  logic              lcl_req,
   input  logic [ADDR_W-1:0] lcl_addr,
   input  logic [DATA_W-1:0] lcl_data,
   output logic              spi_win,
   output logic              lcl_gnt,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   grant_t last_grant;
   logic   lcl_live;
   logic   lcl_win;

   // A request whose grant is on the bus this cycle has already been served;
   // the requester only sees lcl_gnt now, so its lcl_req is still high.
   always_comb begin
      lcl_live = lcl_req & ~lcl_gnt;
      spi_win  = 1'b0;
      lcl_win  = 1'b0;
      if (spi_req && lcl_live) begin
         if (last_grant == LCL) spi_win = 1'b1;
         else                   lcl_win = 1'b1;
      end else if (spi_req) begin
         spi_win = 1'b1;
      end else if (lcl_live) begin
         lcl_win = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LCL;
         wr_en      <= 1'b0;
         lcl_gnt    <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         wr_en   <= spi_win | lcl_win;
         lcl_gnt <= lcl_win;
         if (spi_win) begin
            wr_addr    <= spi_addr;
            wr_data    <= spi_data;
            last_grant <= SPI;
         end else if (lcl_win) begin
            wr_addr    <= lcl_addr;
            wr_data    <= lcl_data;
            last_grant <= LCL;
         end
      end
   end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: frames {rw, addr, data} from synchronized SPI pins and
// arbitrates the resulting writes against a local requester. Macro SPI_ERR_CNT_EN enables err_cnt.
//
//  state | meaning
//  IDLE  | chip select high, waiting for ncs falling edge
//  SHIFT | frame in progress, shifting copi on each sclk rising edge
module spi_frame_ctrl
   import spi_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             copi_s,
   input  logic             ncs_s,
   input  logic             sclk_s,
   spi_frame_ctrl_if.master bus,
   output logic             busy,
   output logic             frame_err,
   input  logic             err_clr,
   output logic [7:0]       err_cnt
);

   localparam int                FRAME_LEN  = 1 + ADDR_W + DATA_W;
   localparam int                CNT_W      = 5;
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_LEN + 1);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS);

   state_t               state;
   logic                 sclk_q;
   logic                 ncs_q;
   logic [FRAME_LEN-1:0] sr;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 done;
   logic                 done_good;
   logic                 spi_pend;
   logic [ADDR_W-1:0]    pend_addr;
   logic [DATA_W-1:0]    pend_data;
   logic                 spi_win;

   logic                 sclk_rise;
   logic                 ncs_fall;
   logic                 ncs_rise;
   logic                 frame_rw;
   logic [ADDR_W-1:0]    frame_addr;
   logic [DATA_W-1:0]    frame_data;
   logic                 frame_wr;

   assign sclk_rise  = sclk_s & ~sclk_q;
   assign ncs_fall   = ~ncs_s & ncs_q;
   assign ncs_rise   = ncs_s & ~ncs_q;
   assign frame_rw   = sr[FRAME_LEN-1];
   assign frame_addr = sr[FRAME_LEN-2 -: ADDR_W];
   assign frame_data = sr[DATA_W-1:0];
   assign frame_wr   = frame_rw && (frame_addr < ADDR_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 1'b0;
         ncs_q  <= 1'b1;
      end else begin
         sclk_q <= sclk_s;
         ncs_q  <= ncs_s;
      end
   end

   // Frame end is evaluated one cycle after ncs_rise (done), so spi_pend and
   // frame_err both appear at the edge after chip select is first sampled high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         sr        <= '0;
         bit_cnt   <= '0;
         done      <= 1'b0;
         done_good <= 1'b0;
         spi_pend  <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         frame_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               if (ncs_fall) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  sr      <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (ncs_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  done_good <= (bit_cnt == CNT_FULL);
               end else if (sclk_rise) begin
                  sr <= {sr[FRAME_LEN-2:0], copi_s};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (spi_win) spi_pend <= 1'b0;

         if (done) begin
            if (!done_good) begin
               frame_err <= 1'b1;
            end else if (frame_wr) begin
               if (spi_pend) begin
                  frame_err <= 1'b1;
               end else begin
                  spi_pend  <= 1'b1;
                  pend_addr <= frame_addr;
                  pend_data <= frame_data;
               end
            end
         end
      end
   end

   spi_wr_arb #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_req  (spi_pend),
      .spi_addr (pend_addr),
      .spi_data (pend_data),
      .lcl_req  (bus.lcl_req),
      .lcl_addr (bus.lcl_addr),
      .lcl_data (bus.lcl_data),
      .spi_win  (spi_win),
      .lcl_gnt  (bus.lcl_gnt),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data)
   );

`ifdef SPI_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'h00;
      end else if (err_clr) begin
         err_cnt <= 8'h00;
      end else if (frame_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'h01;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_cnt        = 8'h00;
`endif

endmodule
